// File: rtl/fp_entry_pkg.sv
// Shared types and key/display constants for the FP entry sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_entry_pkg;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        SEL_OP  = 3'd2,
        START   = 3'd3,
        WAIT    = 3'd4,
        RESULT  = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam logic [3:0] KEY_ADD    = 4'h0;
    localparam logic [3:0] KEY_SUB    = 4'h1;
    localparam logic [3:0] ERR_NIBBLE = 4'hE;

endpackage

// File: rtl/digit_accum.sv
// Shifts hex digits into an operand register, first digit ending up most significant.
// Latency: value updates on the edge a load is taken; full is combinational on that load.
// Backpressure: none; every load is accepted, full marks the DIGITS-th one.
module digit_accum #(
    parameter  int DIGITS = 4,
    localparam int WIDTH  = DIGITS * 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic             full
);

    localparam int            CW   = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    logic [CW-1:0] dcnt;

    assign full = load && (dcnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            dcnt  <= '0;
        end else if (clr) begin
            value <= '0;
            dcnt  <= '0;
        end else if (load) begin
            value <= (value << 4) | WIDTH'(digit);
            dcnt  <= full ? '0 : dcnt + CW'(1);
        end
    end

endmodule

// File: rtl/fp_entry_ctrl.sv
// Sequences keypad entry of A, B and op, starts the FP datapath and shows operands/result.
// Latency: op key -> fpu_start 1 cycle; fpu_done -> display result 1 cycle; watchdog TIMEOUT cycles.
// Backpressure: none; keys outside the entry/op/exit states and done outside WAIT are dropped.
module fp_entry_ctrl
    import fp_entry_pkg::*;
#(
    parameter  int DIGITS  = 4,
    parameter  int TIMEOUT = 255,
    localparam int WIDTH   = DIGITS * 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_value,
    input  logic             key_valid,
    input  logic             fpu_done,
    input  logic [WIDTH-1:0] fpu_result,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             sub,
    output logic             fpu_start,
    output logic [WIDTH-1:0] display,
    output logic [2:0]       phase,
    output logic             busy
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt;
    logic [WIDTH-1:0]  res;
    logic              load_a, load_b, clr;
    logic              full_a, full_b;
    logic              op_key;

    assign op_key = key_valid && ((key_value == KEY_ADD) || (key_value == KEY_SUB));

    digit_accum #(.DIGITS(DIGITS)) u_acc_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (load_a),
        .digit (key_value),
        .value (op_a),
        .full  (full_a)
    );

    digit_accum #(.DIGITS(DIGITS)) u_acc_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (load_b),
        .digit (key_value),
        .value (op_b),
        .full  (full_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ENTER_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ENTER_A: begin
                load_a = key_valid;
                if (full_a) state_d = ENTER_B;
            end
            ENTER_B: begin
                load_b = key_valid;
                if (full_b) state_d = SEL_OP;
            end
            SEL_OP:  if (op_key) state_d = START;
            START:   state_d = WAIT;
            // done wins over the watchdog on the same edge
            WAIT: begin
                if (fpu_done)           state_d = RESULT;
                else if (tcnt == TLAST) state_d = ERROR;
            end
            RESULT, ERROR: begin
                if (key_valid) begin
                    clr     = 1'b1;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub  <= 1'b0;
            res  <= '0;
            tcnt <= '0;
        end else if (clr) begin
            sub  <= 1'b0;
            res  <= '0;
            tcnt <= '0;
        end else begin
            case (state_q)
                SEL_OP: if (op_key) sub <= (key_value == KEY_SUB);
                START:  tcnt <= '0;
                WAIT: begin
                    if (fpu_done)           res  <= fpu_result;
                    else if (tcnt != TLAST) tcnt <= tcnt + TW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        display = op_b;
        case (state_q)
            ENTER_A: display = op_a;
            RESULT:  display = res;
            ERROR:   display = {DIGITS{ERR_NIBBLE}};
            default: display = op_b;
        endcase
    end

    assign fpu_start = (state_q == START);
    assign busy      = (state_q == START) || (state_q == WAIT);
    assign phase     = state_q;

endmodule
